// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared types for the fetch-to-execute decode buffer.
// Holds the decoded control bundle, its field enums, the NOP bundle constant
// and the machine exception cause codes that the queue can raise.
package decode_queue_pkg;

    localparam int Xlen = 32;
    localparam int Ilen = 32;

    typedef enum logic [2:0] {
        InstNone, InstR, InstI, InstS, InstB, InstU, InstJ
    } inst_type_e;

    typedef enum logic [3:0] {
        JmpNone, JmpJal, JmpJalr, JmpBeq, JmpBne, JmpBlt, JmpBge, JmpBltu, JmpBgeu
    } jump_type_e;

    typedef enum logic [2:0] {
        WbNone, WbAlu, WbMem, WbPc4, WbCsr
    } reg_wb_src_e;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd, OpPassB
    } alu_op_e;

    typedef enum logic [3:0] {
        MemNone, MemLb, MemLh, MemLw, MemLbu, MemLhu, MemSb, MemSh, MemSw
    } mem_type_e;

    typedef enum logic [1:0] {
        CsrNone, CsrRw, CsrRs, CsrRc
    } csr_op_e;

    typedef enum logic [3:0] {
        InstAddrMisaligned = 4'd0,
        InstAccessFault    = 4'd1,
        IllegalInst        = 4'd2,
        Breakpoint         = 4'd3,
        EcallM             = 4'd11
    } csr_mcause_e;

    typedef struct packed {
        logic [Xlen-1:0] imm;
        inst_type_e      inst_type;
        jump_type_e      jump_type;
        reg_wb_src_e     reg_wb_src;
        alu_op_e         alu_op;
        mem_type_e       mem_type;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        csr_op_e         csr_op;
        logic            csr_imm;
        logic [11:0]     csr_addr;
        logic            is_fencei;
    } decode_bundle_t;

    // Bundle with no architectural side effect: no writeback, memory, jump or CSR access.
    localparam decode_bundle_t NopBundle = '{
        imm:        '0,
        inst_type:  InstNone,
        jump_type:  JmpNone,
        reg_wb_src: WbNone,
        alu_op:     OpAdd,
        mem_type:   MemNone,
        rs1_addr:   5'd0,
        rs2_addr:   5'd0,
        rd_addr:    5'd0,
        csr_op:     CsrNone,
        csr_imm:    1'b0,
        csr_addr:   12'd0,
        is_fencei:  1'b0
    };

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push, execute-side pop and flush/occupancy of the decode queue.
// master = fetch/backend environment, slave = the queue itself.
// Depth must match the queue instance so that the count width agrees.
interface decode_queue_if #(
    parameter int Depth = 4
);
    import decode_queue_pkg::*;

    localparam int CountW = $clog2(Depth + 1);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [Xlen-1:0]       in_pc;
    logic [Ilen-1:0]       in_inst;
    logic                  in_fault;
    logic                  out_valid;
    logic                  out_ready;
    logic [Xlen-1:0]       out_pc;
    decode_bundle_t        out_bundle;
    logic                  out_expt_valid;
    csr_mcause_e           out_expt_cause;
    logic [Xlen-1:0]       out_expt_value;
    logic [CountW-1:0]     count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_fault, out_ready,
        input  in_ready, out_valid, out_pc, out_bundle,
               out_expt_valid, out_expt_cause, out_expt_value, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_fault, out_ready,
        output in_ready, out_valid, out_pc, out_bundle,
               out_expt_valid, out_expt_cause, out_expt_value, count
    );

endinterface

// File: rtl/decode_queue_decode.sv
// decode_queue_decode: RV32I(+Zicsr, Zifencei) combinational instruction decoder.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: pc/inst in; bundle, expt_valid/expt_cause/expt_value out. Illegal words decode to NopBundle.
module decode_queue_decode
    import decode_queue_pkg::*;
(
    input  logic [Xlen-1:0] pc,
    input  logic [Ilen-1:0] inst,
    output decode_bundle_t  bundle,
    output logic            expt_valid,
    output csr_mcause_e     expt_cause,
    output logic [Xlen-1:0] expt_value
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [Xlen-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            illegal, is_ecall, is_ebreak;
    decode_bundle_t  dec;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Immediate formats written for Xlen == 32.
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec       = NopBundle;
        illegal   = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        case (opcode)
            7'b0110111: begin // lui
                dec.inst_type  = InstU;
                dec.imm        = imm_u;
                dec.alu_op     = OpPassB;
                dec.reg_wb_src = WbAlu;
                dec.rd_addr    = inst[11:7];
            end
            7'b0010111: begin // auipc
                dec.inst_type  = InstU;
                dec.imm        = imm_u;
                dec.reg_wb_src = WbAlu;
                dec.rd_addr    = inst[11:7];
            end
            7'b1101111: begin // jal
                dec.inst_type  = InstJ;
                dec.imm        = imm_j;
                dec.jump_type  = JmpJal;
                dec.reg_wb_src = WbPc4;
                dec.rd_addr    = inst[11:7];
            end
            7'b1100111: begin // jalr
                dec.inst_type  = InstI;
                dec.imm        = imm_i;
                dec.jump_type  = JmpJalr;
                dec.reg_wb_src = WbPc4;
                dec.rs1_addr   = inst[19:15];
                dec.rd_addr    = inst[11:7];
                illegal        = (funct3 != 3'b000);
            end
            7'b1100011: begin // branches compare via subtract
                dec.inst_type = InstB;
                dec.imm       = imm_b;
                dec.alu_op    = OpSub;
                dec.rs1_addr  = inst[19:15];
                dec.rs2_addr  = inst[24:20];
                case (funct3)
                    3'b000:  dec.jump_type = JmpBeq;
                    3'b001:  dec.jump_type = JmpBne;
                    3'b100:  dec.jump_type = JmpBlt;
                    3'b101:  dec.jump_type = JmpBge;
                    3'b110:  dec.jump_type = JmpBltu;
                    3'b111:  dec.jump_type = JmpBgeu;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin // loads
                dec.inst_type  = InstI;
                dec.imm        = imm_i;
                dec.reg_wb_src = WbMem;
                dec.rs1_addr   = inst[19:15];
                dec.rd_addr    = inst[11:7];
                case (funct3)
                    3'b000:  dec.mem_type = MemLb;
                    3'b001:  dec.mem_type = MemLh;
                    3'b010:  dec.mem_type = MemLw;
                    3'b100:  dec.mem_type = MemLbu;
                    3'b101:  dec.mem_type = MemLhu;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin // stores
                dec.inst_type = InstS;
                dec.imm       = imm_s;
                dec.rs1_addr  = inst[19:15];
                dec.rs2_addr  = inst[24:20];
                case (funct3)
                    3'b000:  dec.mem_type = MemSb;
                    3'b001:  dec.mem_type = MemSh;
                    3'b010:  dec.mem_type = MemSw;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin // op-imm
                dec.inst_type  = InstI;
                dec.imm        = imm_i;
                dec.reg_wb_src = WbAlu;
                dec.rs1_addr   = inst[19:15];
                dec.rd_addr    = inst[11:7];
                case (funct3)
                    3'b000: dec.alu_op = OpAdd;
                    3'b010: dec.alu_op = OpSlt;
                    3'b011: dec.alu_op = OpSltu;
                    3'b100: dec.alu_op = OpXor;
                    3'b110: dec.alu_op = OpOr;
                    3'b111: dec.alu_op = OpAnd;
                    3'b001: begin
                        dec.alu_op = OpSll;
                        illegal    = (funct7 != 7'b0000000);
                    end
                    default: begin // 3'b101: shift right, funct7 bit 5 selects arithmetic
                        dec.alu_op = funct7[5] ? OpSra : OpSrl;
                        illegal    = ((funct7 & 7'b1011111) != 7'b0000000);
                    end
                endcase
            end
            7'b0110011: begin // register-register
                dec.inst_type  = InstR;
                dec.reg_wb_src = WbAlu;
                dec.rs1_addr   = inst[19:15];
                dec.rs2_addr   = inst[24:20];
                dec.rd_addr    = inst[11:7];
                case ({funct7, funct3})
                    10'b0000000_000: dec.alu_op = OpAdd;
                    10'b0100000_000: dec.alu_op = OpSub;
                    10'b0000000_001: dec.alu_op = OpSll;
                    10'b0000000_010: dec.alu_op = OpSlt;
                    10'b0000000_011: dec.alu_op = OpSltu;
                    10'b0000000_100: dec.alu_op = OpXor;
                    10'b0000000_101: dec.alu_op = OpSrl;
                    10'b0100000_101: dec.alu_op = OpSra;
                    10'b0000000_110: dec.alu_op = OpOr;
                    10'b0000000_111: dec.alu_op = OpAnd;
                    default:         illegal    = 1'b1;
                endcase
            end
            7'b0001111: begin // fence is a no-op here; fence.i flagged for the backend
                case (funct3)
                    3'b000:  ;
                    3'b001:  dec.is_fencei = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            7'b1110011: begin // system
                if (funct3 == 3'b000) begin
                    if (inst == 32'h0000_0073) begin
                        is_ecall = 1'b1;
                    end else if (inst == 32'h0010_0073) begin
                        is_ebreak = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (funct3 == 3'b100) begin
                    illegal = 1'b1;
                end else begin
                    // csr_imm variants carry a 5-bit zero-extended uimm in the rs1 field
                    dec.inst_type  = InstI;
                    dec.reg_wb_src = WbCsr;
                    dec.rd_addr    = inst[11:7];
                    dec.rs1_addr   = inst[19:15];
                    dec.csr_addr   = inst[31:20];
                    dec.csr_imm    = funct3[2];
                    dec.imm        = {27'b0, inst[19:15]};
                    case (funct3[1:0])
                        2'b01:   dec.csr_op = CsrRw;
                        2'b10:   dec.csr_op = CsrRs;
                        default: dec.csr_op = CsrRc;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        bundle     = illegal ? NopBundle : dec;
        expt_valid = illegal | is_ecall | is_ebreak;
        expt_cause = IllegalInst;
        expt_value = '0;
        if (illegal) begin
            expt_cause = IllegalInst;
            expt_value = Xlen'(inst);
        end else if (is_ebreak) begin
            expt_cause = Breakpoint;
            expt_value = pc;
        end else if (is_ecall) begin
            expt_cause = EcallM;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: Depth-entry circular buffer of fetched {pc, inst, fault}, head decoded for execute.
// Latency: 1 cycle push-to-head; 0 cycles when empty with DECODE_QUEUE_BYPASS_EN defined.
// Backpressure: in_ready = !full && !flush from registered state only; flush drops everything in 1 cycle.
// Ports: clk, rst_n (async active-low); q (decode_queue_if.slave) carries push, pop, flush and count.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int Depth = 4 // power of two, >= 2
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_queue_if.slave q
);
    localparam int IdxW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth + 1);
    localparam logic [IdxW:0] PtrOne = (IdxW + 1)'(1);

    typedef struct packed {
        logic [Xlen-1:0] pc;
        logic [Ilen-1:0] inst;
        logic            fault;
    } entry_t;

    entry_t          store [Depth];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IdxW:0]   wr_ptr, rd_ptr;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic            empty, full, push, pop, bypass_take, head_vld;
    entry_t          head;

    decode_bundle_t  dec_bundle;
    logic            dec_expt_valid;
    csr_mcause_e     dec_expt_cause;
    logic [Xlen-1:0] dec_expt_value;

    assign wr_idx = wr_ptr[IdxW-1:0];
    assign rd_idx = rd_ptr[IdxW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IdxW] != rd_ptr[IdxW]);

    assign q.in_ready = !full && !q.flush;

`ifdef DECODE_QUEUE_BYPASS_EN
    entry_t in_entry;
    assign in_entry    = '{pc: q.in_pc, inst: q.in_inst, fault: q.in_fault};
    // When empty the fetch word is presented directly; if execute takes it now it is never stored.
    assign head        = empty ? in_entry : store[rd_idx];
    assign head_vld    = !empty || q.in_valid;
    assign bypass_take = empty && q.in_valid && q.out_ready && !q.flush;
`else
    assign head        = store[rd_idx];
    assign head_vld    = !empty;
    assign bypass_take = 1'b0;
`endif

    assign q.out_valid = head_vld && !q.flush;

    assign push = q.in_valid && q.in_ready && !bypass_take;
    assign pop  = q.out_valid && q.out_ready && !bypass_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (q.flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
        end
    end

    // Payload storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_idx] <= '{pc: q.in_pc, inst: q.in_inst, fault: q.in_fault};
        end
    end

    // Pointer difference modulo 2*Depth is the occupancy.
    assign q.count = CountW'(wr_ptr - rd_ptr);

    decode_queue_decode u_decode (
        .pc         (head.pc),
        .inst       (head.inst),
        .bundle     (dec_bundle),
        .expt_valid (dec_expt_valid),
        .expt_cause (dec_expt_cause),
        .expt_value (dec_expt_value)
    );

    assign q.out_pc = head.pc;

    // A fetch fault means the word is garbage: it wins over anything the decoder says.
    always_comb begin
        q.out_bundle     = dec_bundle;
        q.out_expt_valid = dec_expt_valid;
        q.out_expt_cause = dec_expt_cause;
        q.out_expt_value = dec_expt_value;
        if (head.fault) begin
            q.out_bundle     = NopBundle;
            q.out_expt_valid = 1'b1;
            q.out_expt_cause = InstAccessFault;
            q.out_expt_value = head.pc;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_queue_if #(.Depth(Depth)) dq ();

    decode_queue #(.Depth(Depth)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (dq)
    );

    typedef enum int {
        KAddi, KAdd, KSub, KLw, KXori, KEcall, KEbreak, KIll, KFaultAddi, KFaultEcall
    } kind_e;

    // One fetch entry plus what execute must see for it, hand-derived per instruction word.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        alu_op_e     alu;
        reg_wb_src_e wb;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        expt;
        csr_mcause_e cause;
        logic [31:0] value;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t model[$];
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input kind_e k, input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.inst = 32'h0; e.fault = 1'b0; e.alu = OpAdd; e.wb = WbNone;
        e.rd = 5'd0; e.imm = 32'h0; e.expt = 1'b0; e.cause = IllegalInst; e.value = 32'h0;
        case (k)
            KAddi:       begin e.inst = 32'h0050_0093; e.wb = WbAlu; e.rd = 5'd1; e.imm = 32'd5; end
            KAdd:        begin e.inst = 32'h0020_81B3; e.wb = WbAlu; e.rd = 5'd3; end
            KSub:        begin e.inst = 32'h4020_81B3; e.wb = WbAlu; e.rd = 5'd3; e.alu = OpSub; end
            KLw:         begin e.inst = 32'h0081_2283; e.wb = WbMem; e.rd = 5'd5; e.imm = 32'd8; end
            KXori:       begin e.inst = 32'hFFF0_C213; e.wb = WbAlu; e.rd = 5'd4; e.alu = OpXor;
                               e.imm = 32'hFFFF_FFFF; end
            KEcall:      begin e.inst = 32'h0000_0073; e.expt = 1'b1; e.cause = EcallM; end
            KEbreak:     begin e.inst = 32'h0010_0073; e.expt = 1'b1; e.cause = Breakpoint; e.value = pc; end
            KIll:        begin e.inst = 32'h0000_0000; e.expt = 1'b1; e.cause = IllegalInst; end
            KFaultAddi:  begin e.inst = 32'h0050_0093; e.fault = 1'b1; e.expt = 1'b1;
                               e.cause = InstAccessFault; e.value = pc; end
            default:     begin e.inst = 32'h0000_0073; e.fault = 1'b1; e.expt = 1'b1;
                               e.cause = InstAccessFault; e.value = pc; end
        endcase
        return e;
    endfunction

    task automatic drive(input kind_e k, input logic [31:0] pc, input logic v,
                         input logic rdy, input logic fl);
        cur          = mk(k, pc);
        dq.in_valid  = v;
        dq.in_pc     = cur.pc;
        dq.in_inst   = cur.inst;
        dq.in_fault  = cur.fault;
        dq.out_ready = rdy;
        dq.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference queue: checked on every falling edge, then advanced with the inputs
    // that will be sampled at the following rising edge.
    always @(negedge clk) begin
        exp_t head;
        bit   has_head, from_in, exp_valid, exp_ready;
        if (!rst_n) begin
            model.delete();
            chk("rst_out_valid", 32'(dq.out_valid), 32'd0);
            chk("rst_count", 32'(dq.count), 32'd0);
            chk("rst_in_ready", 32'(dq.in_ready), 32'd1);
        end else begin
            has_head = (model.size() > 0);
            from_in  = 1'b0;
            if (has_head) head = model[0];
`ifdef DECODE_QUEUE_BYPASS_EN
            if (!has_head && dq.in_valid) begin
                has_head = 1'b1;
                head     = cur;
                from_in  = 1'b1;
            end
`endif
            exp_valid = has_head && !dq.flush;
            exp_ready = (model.size() < Depth) && !dq.flush;
            chk("in_ready", 32'(dq.in_ready), 32'(exp_ready));
            chk("count", 32'(dq.count), 32'(model.size()));
            chk("out_valid", 32'(dq.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("head_pc", dq.out_pc, head.pc);
                chk("head_alu", 32'(dq.out_bundle.alu_op), 32'(head.alu));
                chk("head_wb", 32'(dq.out_bundle.reg_wb_src), 32'(head.wb));
                chk("head_rd", 32'(dq.out_bundle.rd_addr), 32'(head.rd));
                chk("head_imm", dq.out_bundle.imm, head.imm);
                chk("head_expt", 32'(dq.out_expt_valid), 32'(head.expt));
                if (head.expt) begin
                    chk("head_cause", 32'(dq.out_expt_cause), 32'(head.cause));
                    chk("head_value", dq.out_expt_value, head.value);
                end
            end
            if (dq.flush) begin
                model.delete();
            end else begin
                if (exp_valid && dq.out_ready && !from_in) void'(model.pop_front());
                if (dq.in_valid && exp_ready && !(from_in && dq.out_ready)) model.push_back(cur);
            end
        end
    end

    task automatic exc(input kind_e k, input logic [31:0] pc, input csr_mcause_e c,
                       input logic [31:0] v);
        drive(k, pc, 1'b1, 1'b0, 1'b0);
        step();
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("exc_out_valid", 32'(dq.out_valid), 32'd1);
        chk("exc_flag", 32'(dq.out_expt_valid), 32'd1);
        chk("exc_cause", 32'(dq.out_expt_cause), 32'(c));
        chk("exc_value", dq.out_expt_value, v);
        dq.out_ready = 1'b1;
        step();
        dq.out_ready = 1'b0;
    endtask

    kind_e sk [4] = '{KLw, KXori, KAddi, KAdd};

    initial begin
        rst_n = 1'b0;
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(dq.count), 32'd0);
        chk("reset_in_ready", 32'(dq.in_ready), 32'd1);
        chk("reset_out_valid", 32'(dq.out_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // Fill to full with execute stalled, then one refused push.
        for (int i = 0; i < 4; i++) begin
            drive(KAddi, 32'(i * 4), 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("fill_count", 32'(dq.count), 32'd4);
        chk("fill_in_ready", 32'(dq.in_ready), 32'd0);
        drive(KAddi, 32'h10, 1'b1, 1'b0, 1'b0);
        step();
        chk("full_hold_count", 32'(dq.count), 32'd4);

        // Drain in order; the push offered while full is not taken.
        drive(KAddi, 32'h10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(dq.out_valid), 32'd1);
            chk("drain_pc", dq.out_pc, 32'(i * 4));
            chk("drain_alu", 32'(dq.out_bundle.alu_op), 32'(OpAdd));
            step();
            if (i == 0) dq.in_valid = 1'b0;
        end
        chk("drain_count", 32'(dq.count), 32'd0);
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        step();

        // Streaming with two entries resident: occupancy constant, pointers wrap.
        drive(KAdd, 32'h100, 1'b1, 1'b0, 1'b0);
        step();
        drive(KSub, 32'h104, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(sk[i % 4], 32'h200 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
            step();
            chk("stream_count", 32'(dq.count), 32'd2);
        end
        drive(KAddi, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        chk("stream_drain_count", 32'(dq.count), 32'd0);

        // Flush with three queued and a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(KAddi, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(KAdd, 32'h50C, 1'b1, 1'b1, 1'b1);
        #1;
        chk("flush_out_valid", 32'(dq.out_valid), 32'd0);
        chk("flush_in_ready", 32'(dq.in_ready), 32'd0);
        step();
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_count", 32'(dq.count), 32'd0);
        chk("flush_empty", 32'(dq.out_valid), 32'd0);
        step();

        // Exceptions: illegal word, breakpoint, fault beats ecall, plain ecall, faulting addi.
        exc(KIll,        32'h300, IllegalInst,     32'h0);
        exc(KEbreak,     32'h304, Breakpoint,      32'h304);
        exc(KFaultEcall, 32'h308, InstAccessFault, 32'h308);
        exc(KEcall,      32'h30C, EcallM,          32'h0);
        exc(KFaultAddi,  32'h310, InstAccessFault, 32'h310);
        step();

        // Empty queue, push with execute ready.
        drive(KAddi, 32'h400, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        chk("byp_same_valid", 32'(dq.out_valid), 32'd1);
        chk("byp_same_pc", dq.out_pc, 32'h400);
`else
        chk("byp_same_valid", 32'(dq.out_valid), 32'd0);
`endif
        step();
        drive(KAddi, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        chk("byp_next_valid", 32'(dq.out_valid), 32'd0);
        chk("byp_next_count", 32'(dq.count), 32'd0);
`else
        chk("byp_next_valid", 32'(dq.out_valid), 32'd1);
        chk("byp_next_pc", dq.out_pc, 32'h400);
`endif
        step();
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset with entries queued.
        drive(KXori, 32'h600, 1'b1, 1'b0, 1'b0);
        step();
        drive(KLw, 32'h604, 1'b1, 1'b0, 1'b0);
        step();
        drive(KAddi, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(dq.count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(dq.out_valid), 32'd0);
        chk("arst_count", 32'(dq.count), 32'd0);
        chk("arst_in_ready", 32'(dq.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_arst_count", 32'(dq.count), 32'd0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
